// File: rtl/log2_peak_meter_if.sv
// log2_peak_meter_if: sample stream in, peak/state/overload flags out.
// The upstream log2 stage is the master; the meter is the slave.
interface log2_peak_meter_if;
    logic       din_valid;
    logic [7:0] din;
    logic       clr;
    logic [7:0] peak;
    logic       peak_valid;
    logic [1:0] state;
    logic       over;

    modport master (
        output din_valid, din, clr,
        input  peak, peak_valid, state, over
    );

    modport slave (
        input  din_valid, din, clr,
        output peak, peak_valid, state, over
    );
endinterface

// File: rtl/log2_peak_meter.sv
// log2_peak_meter: hold-then-decay peak tracker for 4.4 log2 codes.
// Optional macro LOG2_PEAK_METER_OVER_EN adds a sticky full-scale flag.
module log2_peak_meter #(
    parameter int unsigned HOLD_SAMPLES = 1024,
    parameter int unsigned DECAY_DIV    = 16,
    parameter int unsigned DECAY_STEP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    log2_peak_meter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DECAY = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    localparam logic [15:0] HOLD_N = 16'(HOLD_SAMPLES);
    localparam logic [7:0]  DIV_N  = 8'(DECAY_DIV);
    localparam logic [7:0]  STEP_N = 8'(DECAY_STEP);

    state_t      state_q;
    logic [7:0]  peak_q;
    logic        pv_q;
    logic [15:0] hold_cnt;
    logic [7:0]  div_cnt;

    logic [7:0]  dec_val;
    logic [7:0]  dec_peak;
    logic [15:0] hold_nxt;
    logic [7:0]  div_nxt;

    // Next-count and decayed-peak values, floored at zero and at the sample.
    always_comb begin
        dec_val  = (peak_q > STEP_N) ? (peak_q - STEP_N) : 8'd0;
        dec_peak = (dec_val > bus.din) ? dec_val : bus.din;
        hold_nxt = hold_cnt + 16'd1;
        div_nxt  = div_cnt + 8'd1;
    end

    // Peak tracking FSM; every accepted sample produces one peak_valid pulse.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr) begin
            state_q  <= ST_IDLE;
            peak_q   <= 8'd0;
            pv_q     <= 1'b0;
            hold_cnt <= 16'd0;
            div_cnt  <= 8'd0;
        end else begin
            pv_q <= 1'b0;
            if (state_q == ST_BAD) begin
                state_q  <= ST_IDLE;
                peak_q   <= 8'd0;
                hold_cnt <= 16'd0;
                div_cnt  <= 8'd0;
            end else if (bus.din_valid) begin
                pv_q <= 1'b1;
                if (bus.din >= peak_q) begin
                    // A zero sample at zero peak is the only way to stay idle.
                    peak_q   <= bus.din;
                    hold_cnt <= 16'd0;
                    div_cnt  <= 8'd0;
                    state_q  <= (bus.din == 8'd0) ? ST_IDLE : ST_HOLD;
                end else begin
                    case (state_q)
                        ST_HOLD: begin
                            if (hold_nxt == HOLD_N) begin
                                state_q  <= ST_DECAY;
                                hold_cnt <= 16'd0;
                                div_cnt  <= 8'd0;
                            end else begin
                                hold_cnt <= hold_nxt;
                            end
                        end
                        ST_DECAY: begin
                            if (div_nxt == DIV_N) begin
                                div_cnt <= 8'd0;
                                peak_q  <= dec_peak;
                                if (dec_peak == 8'd0) begin
                                    state_q <= ST_IDLE;
                                end else if (dec_peak == bus.din) begin
                                    state_q  <= ST_HOLD;
                                    hold_cnt <= 16'd0;
                                end
                            end else begin
                                div_cnt <= div_nxt;
                            end
                        end
                        default: begin
                            state_q <= state_q;
                        end
                    endcase
                end
            end
        end
    end

`ifdef LOG2_PEAK_METER_OVER_EN
    logic over_q;

    // Sticky full-scale flag, cleared only by clear or reset.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr) begin
            over_q <= 1'b0;
        end else if (bus.din_valid && bus.din == 8'hFF) begin
            over_q <= 1'b1;
        end
    end

    assign bus.over = over_q;
`else
    assign bus.over = 1'b0;
`endif

    assign bus.peak       = peak_q;
    assign bus.peak_valid = pv_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_log2_peak_meter.sv
// tb_log2_peak_meter: directed checks with HOLD=4, DIV=2, STEP=1.
// Inputs change on the falling edge; outputs are read one falling edge later.
module tb_log2_peak_meter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

`ifdef LOG2_PEAK_METER_OVER_EN
    localparam logic OVER_EXP = 1'b1;
`else
    localparam logic OVER_EXP = 1'b0;
`endif

    log2_peak_meter_if bus ();

    log2_peak_meter #(
        .HOLD_SAMPLES(4),
        .DECAY_DIV   (2),
        .DECAY_STEP  (1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given inputs; returns at the next falling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic c);
        bus.din_valid = v;
        bus.din       = d;
        bus.clr       = c;
        @(negedge clk);
        bus.din_valid = 1'b0;
        bus.clr       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h80, 1'b0);
            n_cmp++;
            if (bus.peak !== 8'h00 || bus.state !== 2'd0 ||
                bus.peak_valid !== 1'b0 || bus.over !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold peak=%h st=%0d pv=%b ov=%b exp 00/0/0/0",
                         bus.peak, bus.state, bus.peak_valid, bus.over);
            end
        end
        rst_n = 1'b1;
        step(1'b1, 8'h80, 1'b0);
        n_cmp++;
        if (bus.peak !== 8'h80 || bus.state !== 2'd1 || bus.peak_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_first peak=%h st=%0d pv=%b exp 80/1/1",
                     bus.peak, bus.state, bus.peak_valid);
        end
        step(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (bus.peak_valid !== 1'b0 || bus.peak !== 8'h80) begin
            n_bad++;
            $display("FAIL reset_pulse pv=%b peak=%h exp 0/80",
                     bus.peak_valid, bus.peak);
        end
    endtask

    task automatic test_idle_zero();
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h00, 1'b0);
        n_cmp++;
        if (bus.peak !== 8'h00 || bus.state !== 2'd0 || bus.peak_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_zero peak=%h st=%0d pv=%b exp 00/0/1",
                     bus.peak, bus.state, bus.peak_valid);
        end
    endtask

    task automatic test_decay();
        logic [1:0] st_exp;
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h50, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h10, 1'b0);
            st_exp = (i == 3) ? 2'd2 : 2'd1;
            n_cmp++;
            if (bus.state !== st_exp || bus.peak !== 8'h50) begin
                n_bad++;
                $display("FAIL decay_hold%0d st=%0d peak=%h exp %0d/50",
                         i, bus.state, bus.peak, st_exp);
            end
        end
        step(1'b1, 8'h10, 1'b0);
        n_cmp++;
        if (bus.peak !== 8'h50 || bus.state !== 2'd2) begin
            n_bad++;
            $display("FAIL decay_div1 peak=%h st=%0d exp 50/2", bus.peak, bus.state);
        end
        step(1'b1, 8'h10, 1'b0);
        n_cmp++;
        if (bus.peak !== 8'h4F || bus.state !== 2'd2) begin
            n_bad++;
            $display("FAIL decay_4f peak=%h st=%0d exp 4f/2", bus.peak, bus.state);
        end
        step(1'b1, 8'h10, 1'b0);
        step(1'b1, 8'h10, 1'b0);
        n_cmp++;
        if (bus.peak !== 8'h4E || bus.state !== 2'd2) begin
            n_bad++;
            $display("FAIL decay_4e peak=%h st=%0d exp 4e/2", bus.peak, bus.state);
        end
    endtask

    task automatic test_equal_restart();
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h21, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'h00, 1'b0);
        n_cmp++;
        if (bus.peak !== 8'h20 || bus.state !== 2'd2) begin
            n_bad++;
            $display("FAIL eq_setup peak=%h st=%0d exp 20/2", bus.peak, bus.state);
        end
        step(1'b1, 8'h20, 1'b0);
        n_cmp++;
        if (bus.peak !== 8'h20 || bus.state !== 2'd1) begin
            n_bad++;
            $display("FAIL eq_restart peak=%h st=%0d exp 20/1", bus.peak, bus.state);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b0);
        n_cmp++;
        if (bus.state !== 2'd1) begin
            n_bad++;
            $display("FAIL eq_hold3 st=%0d exp 1", bus.state);
        end
        step(1'b1, 8'h00, 1'b0);
        n_cmp++;
        if (bus.state !== 2'd2 || bus.peak !== 8'h20) begin
            n_bad++;
            $display("FAIL eq_hold4 st=%0d peak=%h exp 2/20", bus.state, bus.peak);
        end
    endtask

    task automatic test_floor();
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h21, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'h20, 1'b0);
        n_cmp++;
        if (bus.peak !== 8'h20 || bus.state !== 2'd1) begin
            n_bad++;
            $display("FAIL floor_din peak=%h st=%0d exp 20/1", bus.peak, bus.state);
        end
    endtask

    task automatic test_to_idle();
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h01, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h00, 1'b0);
        n_cmp++;
        if (bus.peak !== 8'h01 || bus.state !== 2'd2) begin
            n_bad++;
            $display("FAIL idle_pre peak=%h st=%0d exp 01/2", bus.peak, bus.state);
        end
        step(1'b1, 8'h00, 1'b0);
        n_cmp++;
        if (bus.peak !== 8'h00 || bus.state !== 2'd0) begin
            n_bad++;
            $display("FAIL idle_end peak=%h st=%0d exp 00/0", bus.peak, bus.state);
        end
    endtask

    task automatic test_gaps();
        int bad;
        bad = 0;
        step(1'b1, 8'h40, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 8'hFF, 1'b0);
            if (bus.peak !== 8'h40 || bus.state !== 2'd1 || bus.peak_valid !== 1'b0)
                bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL gap_idle bad_cycles=%0d exp 0 (peak=%h st=%0d)",
                     bad, bus.peak, bus.state);
        end
        step(1'b1, 8'h00, 1'b0);
        n_cmp++;
        if (bus.state !== 2'd1) begin
            n_bad++;
            $display("FAIL gap_hold3 st=%0d exp 1", bus.state);
        end
        step(1'b1, 8'h00, 1'b0);
        n_cmp++;
        if (bus.state !== 2'd2 || bus.peak !== 8'h40) begin
            n_bad++;
            $display("FAIL gap_hold4 st=%0d peak=%h exp 2/40", bus.state, bus.peak);
        end
    endtask

    task automatic test_clr();
        step(1'b1, 8'h80, 1'b0);
        step(1'b1, 8'hFF, 1'b1);
        n_cmp++;
        if (bus.peak !== 8'h00 || bus.state !== 2'd0 ||
            bus.over !== 1'b0 || bus.peak_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_prio peak=%h st=%0d ov=%b pv=%b exp 00/0/0/0",
                     bus.peak, bus.state, bus.over, bus.peak_valid);
        end
    endtask

    task automatic test_over();
        int bad;
        bad = 0;
        step(1'b1, 8'hFF, 1'b0);
        n_cmp++;
        if (bus.peak !== 8'hFF || bus.state !== 2'd1 || bus.over !== OVER_EXP) begin
            n_bad++;
            $display("FAIL over_set peak=%h st=%0d ov=%b exp ff/1/%b",
                     bus.peak, bus.state, bus.over, OVER_EXP);
        end
        for (int i = 0; i < 4 + 255 * 2; i++) begin
            step(1'b1, 8'h00, 1'b0);
            if (bus.over !== OVER_EXP) bad++;
        end
        n_cmp++;
        if (bus.peak !== 8'h00 || bus.state !== 2'd0 || bad != 0) begin
            n_bad++;
            $display("FAIL over_decay peak=%h st=%0d ov_bad=%0d exp 00/0/0",
                     bus.peak, bus.state, bad);
        end
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (bus.over !== 1'b0) begin
            n_bad++;
            $display("FAIL over_clr ov=%b exp 0", bus.over);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 8'h60, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h00, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 8'h00, 1'b0);
        rst_n = 1'b1;
        n_cmp++;
        if (bus.peak !== 8'h00 || bus.state !== 2'd0 || bus.peak_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid peak=%h st=%0d pv=%b exp 00/0/0",
                     bus.peak, bus.state, bus.peak_valid);
        end
        step(1'b1, 8'h30, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b0);
        n_cmp++;
        if (bus.state !== 2'd1 || bus.peak !== 8'h30) begin
            n_bad++;
            $display("FAIL rst_post3 st=%0d peak=%h exp 1/30", bus.state, bus.peak);
        end
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        n_cmp++;
        if (bus.state !== 2'd2 || bus.peak !== 8'h30) begin
            n_bad++;
            $display("FAIL rst_post5 st=%0d peak=%h exp 2/30", bus.state, bus.peak);
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = 8'h00;
        bus.clr       = 1'b0;
        @(negedge clk);
        test_reset();
        test_idle_zero();
        test_decay();
        test_equal_restart();
        test_floor();
        test_to_idle();
        test_gaps();
        test_clr();
        test_over();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/log2_peak_meter.md
LOG2_PEAK_METER -- requirements
Module: log2_peak_meter

Interface
REQ-001 Parameter HOLD_SAMPLES, default 1024, meaning: accepted samples the peak is held before decay starts (range 1..65535).
REQ-002 Parameter DECAY_DIV, default 16, meaning: accepted samples per decay step (range 1..255).
REQ-003 Parameter DECAY_STEP, default 1, meaning: LSBs subtracted from the peak per decay step (range 1..15).
REQ-004 CLK  input  1  single clock; all logic is rising-edge.
REQ-005 RST_N  input  1  reset; synchronous and active-low.
REQ-006 DIN_VALID  input  1  DIN carries a new log2 code this cycle.
REQ-007 DIN  input  8  unsigned 4.4 log2 code from the upstream single-cycle log2 stage (integer nibble, fraction nibble).
REQ-008 CLR  input  1  synchronous clear of peak, state and flags.
REQ-009 PEAK  output  8  current held/decaying peak, same 4.4 format.
REQ-010 PEAK_VALID  output  1  one-cycle pulse: PEAK updated from an accepted sample.
REQ-011 STATE  output  2  encoded state: 0 IDLE, 1 HOLD, 2 DECAY.
REQ-012 OVER  output  1  sticky overload flag (see Configuration).

Function
REQ-013 A sample SHALL be accepted on any rising edge with DIN_VALID=1, CLR=0, RST_N=1; no back-pressure exists, and every valid sample is consumed.
REQ-014 Latency SHALL be 1 cycle: PEAK, STATE and PEAK_VALID reflect sample N on the edge after acceptance; PEAK_VALID is asserted exactly one cycle per accepted sample.
REQ-015 Capture rule: if DIN >= PEAK, PEAK SHALL load DIN, the hold counter SHALL reset to 0, the decay divider SHALL reset to 0, and STATE SHALL become HOLD (from any state; an equal value restarts the hold).
REQ-016 IDLE (PEAK=0): DIN=0 SHALL leave STATE IDLE; DIN>0 SHALL go to HOLD via REQ-015.
REQ-017 HOLD: when DIN < PEAK, the hold counter SHALL increment; on the sample that brings the count to HOLD_SAMPLES, STATE SHALL become DECAY with the divider at 0 and PEAK unchanged.
REQ-018 DECAY: when DIN < PEAK, the divider SHALL increment; on the sample that brings it to DECAY_DIV, the divider SHALL return to 0 and PEAK SHALL become max(PEAK-DECAY_STEP, DIN) (floor at the incoming sample, never below 0).
REQ-019 If the decay result equals DIN and DIN>0, REQ-015 SHALL apply (HOLD restart); if the result is 0, STATE SHALL become IDLE.
REQ-020 Counters SHALL advance only on accepted samples; idle cycles (DIN_VALID=0) SHALL change nothing.
REQ-021 The hold counter SHALL be 16 bits and the divider 8 bits; neither SHALL wrap, since both are reset by the state transitions above.
REQ-022 CLR SHALL have priority over a simultaneous valid sample: the sample is discarded, PEAK=0, STATE=IDLE, counters=0, OVER=0, PEAK_VALID=0 next cycle.
REQ-023 STATE encoding 3 SHALL be unreachable; if it is ever entered, the next edge SHALL force IDLE with PEAK=0.

Reset
REQ-024 With RST_N=0 at a rising edge: PEAK=0, PEAK_VALID=0, STATE=IDLE (0), OVER=0, all counters 0; RST_N overrides CLR and DIN_VALID.
REQ-025 Reset asserted mid-HOLD or mid-DECAY SHALL abandon the operation, with no residual count after release.

Configuration
REQ-026 Macro LOG2_PEAK_METER_OVER_EN: when defined, OVER SHALL set on acceptance of DIN=8'hFF (full-scale input) and stay set until CLR or reset; it is independent of PEAK decay.
REQ-027 Without LOG2_PEAK_METER_OVER_EN, OVER SHALL be constant 0 and no overload register SHALL exist; all other behaviour is identical.

Verification (HOLD_SAMPLES=4, DECAY_DIV=2, DECAY_STEP=1 unless stated)
REQ-028 Reset with DIN_VALID=1, DIN=8'h80 -> PEAK=0, STATE=0, PEAK_VALID=0 throughout reset; after release, the first sample 8'h80 gives PEAK=8'h80, STATE=1 one cycle later.
REQ-029 Samples 8'h50, then 0x10 x4 -> STATE=2 after the 4th 0x10; a further 0x10 x2 -> PEAK=8'h4F; 0x10 x2 more -> PEAK=8'h4E.
REQ-030 During DECAY with PEAK=8'h20, DIN=8'h20 -> STATE=1, PEAK=8'h20, hold count restarted (4 more lower samples needed to re-enter DECAY).
REQ-031 PEAK=8'h01 in DECAY, DIN=0 x2 -> PEAK=0, STATE=0; DIN_VALID=0 for 100 cycles mid-HOLD -> no state or PEAK change.
REQ-032 CLR=1 and DIN_VALID=1 with DIN=8'hFF on the same edge -> PEAK=0, STATE=0, OVER=0, PEAK_VALID=0.
REQ-033 With LOG2_PEAK_METER_OVER_EN: DIN=8'hFF -> OVER=1, persisting through full decay to IDLE until CLR; without the macro, OVER=0 always.
